mult_acc_4b: RTL
================

MULT_ACC_4B -- requirements
Module: mult_acc_4b

Interface
REQ-001 The block SHALL have one parameter: ACC_W, default 12, accumulator/result width in bits (ACC_W >= 8).
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_x  input  4  unsigned multiplicand.
- in_y  input  4  unsigned multiplier.
- in_last  input  1  beat closes the current sequence.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  sum of products of the sequence.
- out_count  output  8  beats in the sequence.
- out_ovf  output  1  sticky overflow of the accumulator.
REQ-003 Clocking and reset SHALL be exactly: one clock, clk; asynchronous active-high reset, rst.

Function
REQ-004 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-005 Product stage: on acceptance, p_reg SHALL take in_x*in_y (8 bits, unsigned), p_valid SHALL be set to 1, and p_last SHALL take in_last. With no acceptance, p_valid SHALL be cleared to 0.
REQ-006 Accumulate stage: on an edge with p_valid=1:
- acc SHALL take acc + zero-extended p_reg, truncated to ACC_W bits.
- cnt SHALL increment, saturating at 255.
- A carry out of ACC_W bits SHALL set ovf.
REQ-007 FSM states SHALL be IDLE, ACCUM and HOLD, with these transitions:
- IDLE -> ACCUM on p_valid && !p_last.
- IDLE or ACCUM -> HOLD on p_valid && p_last.
- HOLD -> IDLE on out_valid && out_ready.
REQ-008 On entering HOLD, out_sum, out_count and out_ovf SHALL hold the final values, including the last product. These values SHALL stay stable while in HOLD.
REQ-009 out_valid SHALL be 1 exactly in HOLD. Latency SHALL be 2 edges from acceptance of the last beat to out_valid=1.
REQ-010 in_ready SHALL be 0 when state==HOLD or (p_valid && p_last), and 1 otherwise. in_ready SHALL be combinational from registered state only, with no path from in_valid.
REQ-011 On the HOLD->IDLE edge, acc, cnt and ovf SHALL clear to 0.
REQ-012 No beat SHALL be accepted during HOLD, and no beat of the next sequence SHALL enter before the result handshake completes.
REQ-013 out_sum and out_count SHALL show the running acc and cnt outside HOLD; only values qualified by out_valid are meaningful.
REQ-014 A single-beat sequence (in_last on the first beat) SHALL go IDLE->HOLD directly.

Reset
REQ-015 rst=1 SHALL asynchronously force:
- state = IDLE.
- p_valid, p_last, p_reg, acc, cnt, ovf = 0.
- out_valid, out_sum, out_count, out_ovf = 0.
REQ-016 in_ready SHALL be 1 on the first edge after rst deasserts.
REQ-017 Reset mid-sequence or in HOLD SHALL discard all partial state and any pending result.

Configuration
REQ-018 With MULT_ACC_SATURATE_EN defined, an accumulation that would exceed 2^ACC_W-1 SHALL clamp acc to all-ones and set ovf.
REQ-019 Without MULT_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W and set ovf.

Structure
REQ-020 A shared package mult_acc_pkg SHALL hold:
- the FSM state typedef (IDLE/ACCUM/HOLD).
- the operand width constant (4).
- the product width constant (8).
- the count width constant (8).
REQ-021 The multiply SHALL be a combinational sub-module, mul4_ppr: an unsigned 4x4 partial-product compressor tree plus prefix-adder final stage. It SHALL be instantiated once, feeding p_reg.

Verification
REQ-022 Single beat 15x15, last=1 -> out_valid=1 two edges after acceptance; out_sum=225, out_count=1, out_ovf=0.
REQ-023 Beats 3x4, 5x6, 7x2(last) back-to-back -> out_sum=56, out_count=3; in_ready=0 from the edge after the last beat until the handshake.
REQ-024 ACC_W=12, 16 beats of 15x15 -> out_sum=3600, out_ovf=0. With 19 beats:
- Without the macro -> out_sum=179, out_ovf=1.
- With MULT_ACC_SATURATE_EN -> out_sum=4095, out_ovf=1.
REQ-025 Result pending, out_ready=0 for 5 cycles while in_valid=1 -> out_valid held, out_sum stable, in_ready=0, no beat accepted. Then out_ready=1 -> IDLE, and the next sequence 2x3(last) gives out_sum=6.
REQ-026 rst pulse after beats 9x9, 8x8 (no last) -> all outputs 0. Then 1x0, 0x7(last) -> out_sum=0, out_count=2.

Source files
------------

// File: rtl/mult_acc_pkg.sv
// Shared types and widths for the 4-bit multiply-accumulate block.
// Holds the sequence FSM state encoding and operand/product/count widths.
package mult_acc_pkg;

    localparam int OPER_W = 4;
    localparam int PROD_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mul4_ppr.sv
// Combinational unsigned 4x4 multiplier: partial-product rows reduced by two
// 3:2 carry-save stages, then a Kogge-Stone prefix adder for the final sum.
module mul4_ppr
    import mult_acc_pkg::*;
(
    input  logic [OPER_W-1:0] a,
    input  logic [OPER_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    localparam int W = PROD_W;

    logic [W-1:0] row [OPER_W];
    logic [W-1:0] s1, c1, s2, c2;

    generate
        for (genvar gi = 0; gi < OPER_W; gi++) begin : g_row
            assign row[gi] = {{(W-OPER_W){1'b0}}, a & {OPER_W{b[gi]}}} << gi;
        end
    endgenerate

    // The true product is below 2^8, so dropping carries past bit 7 is exact.
    assign s1 = row[0] ^ row[1] ^ row[2];
    assign c1 = ((row[0] & row[1]) | (row[0] & row[2]) | (row[1] & row[2])) << 1;
    assign s2 = s1 ^ c1 ^ row[3];
    assign c2 = ((s1 & c1) | (s1 & row[3]) | (c1 & row[3])) << 1;

    // Prefix network over bits 0..6 only: bit 7 never produces a needed carry,
    // and group propagates are built only where a later level consumes them.
    logic [W-1:0] p0;
    logic [W-2:0] g0, g1, g2, g3;
    logic [W-2:2] p1;
    logic [W-2:4] p2;

    assign p0 = s2 ^ c2;
    assign g0 = s2[W-2:0] & c2[W-2:0];

    generate
        for (genvar gi = 0; gi <= W-2; gi++) begin : g_lvl1
            if (gi >= 1) begin : g_cmb
                assign g1[gi] = g0[gi] | (p0[gi] & g0[gi-1]);
            end else begin : g_pass
                assign g1[gi] = g0[gi];
            end
            if (gi >= 2) begin : g_prop
                assign p1[gi] = p0[gi] & p0[gi-1];
            end
        end

        for (genvar gi = 0; gi <= W-2; gi++) begin : g_lvl2
            if (gi >= 2) begin : g_cmb
                assign g2[gi] = g1[gi] | (p1[gi] & g1[gi-2]);
            end else begin : g_pass
                assign g2[gi] = g1[gi];
            end
            if (gi >= 4) begin : g_prop
                assign p2[gi] = p1[gi] & p1[gi-2];
            end
        end

        for (genvar gi = 0; gi <= W-2; gi++) begin : g_lvl3
            if (gi >= 4) begin : g_cmb
                assign g3[gi] = g2[gi] | (p2[gi] & g2[gi-4]);
            end else begin : g_pass
                assign g3[gi] = g2[gi];
            end
        end

        for (genvar gi = 0; gi < W; gi++) begin : g_sum
            if (gi == 0) begin : g_lsb
                assign p[gi] = p0[gi];
            end else begin : g_bit
                assign p[gi] = p0[gi] ^ g3[gi-1];
            end
        end
    endgenerate

endmodule

// File: rtl/mult_acc_4b.sv
// Streaming 4x4 multiply-accumulate: sums products of a beat sequence and
// holds the result until handshaken. Define MULT_ACC_SATURATE_EN to clamp.
module mult_acc_4b
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPER_W-1:0] in_x,
    input  logic [OPER_W-1:0] in_y,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_reg, state_next;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  p_reg;
    logic               p_valid_reg;
    logic               p_last_reg;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic [ACC_W:0]     sum_ext;
    logic               accept;
    logic               release_hold;

    mul4_ppr u_mul (
        .a (in_x),
        .b (in_y),
        .p (prod)
    );

    // Ready depends only on registered state so the upstream sees no loop.
    assign in_ready     = !((state_reg == HOLD) || (p_valid_reg && p_last_reg));
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state_reg == HOLD);
    assign release_hold = (state_reg == HOLD) && out_ready;

    assign out_sum   = acc_reg;
    assign out_count = cnt_reg;
    assign out_ovf   = ovf_reg;

    assign sum_ext = {1'b0, acc_reg} + {{(ACC_W+1-PROD_W){1'b0}}, p_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (p_valid_reg && p_last_reg) begin
                    state_next = HOLD;
                end else if (p_valid_reg) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (p_valid_reg && p_last_reg) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (release_hold) begin
            acc_next = '0;
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (p_valid_reg) begin
`ifdef MULT_ACC_SATURATE_EN
            acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_next = sum_ext[ACC_W-1:0];
`endif
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + 1'b1;
            end
            ovf_next = ovf_reg | sum_ext[ACC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            p_valid_reg <= 1'b0;
            p_last_reg  <= 1'b0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            p_valid_reg <= accept;
            if (accept) begin
                p_reg      <= prod;
                p_last_reg <= in_last;
            end
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
        end
    end

endmodule
